roce_stack_aximm_to_axis: RTL and testbench
===========================================

// Module: roce_stack_aximm_to_axis
// PURPOSE
//  AXI4 memory-mapped responder that lets an AXI4 master (host/DMA path) target the RoCE stack data plane.
//  - Write bursts become one write request (vaddr, byte length) plus an AXI-Stream payload.
//  - Read bursts become one read request, and the returned AXI-Stream is replayed as R beats.
//  - It is the slave-side counterpart of the RDMA-request-to-AXI-MM master path.
// PARAMETERS
//  AXI4_DATA_WIDTH  512  data width of the AXI4 and AXIS buses; BEAT_BYTES = AXI4_DATA_WIDTH/8
// PORTS
//  axis_aclk_i                 in   1      single clock for all interfaces
//  aresetn_i                   in   1      asynchronous, active-low reset
//  s_axi_aw{id,addr,len,size,burst,valid}_i / s_axi_awready_o          in/out  1,64,8,3,2,1 / 1   AXI4 write address
//  s_axi_w{data,strb,last,valid}_i / s_axi_wready_o                    in/out  DW,DW/8,1,1 / 1    AXI4 write data
//  s_axi_b{id,resp,valid}_o / s_axi_bready_i                           out/in  1,2,1 / 1          AXI4 write response
//  s_axi_ar{id,addr,len,size,burst,valid}_i / s_axi_arready_o          in/out  1,64,8,3,2,1 / 1   AXI4 read address
//  s_axi_r{id,data,resp,last,valid}_o / s_axi_rready_i                 out/in  1,DW,2,1,1 / 1     AXI4 read data
//  m_wr_req_{valid,vaddr,len}_o / m_wr_req_ready_i                     out/in  1,64,28 / 1        write request to stack
//  m_axis_wr_{tdata,tkeep,tlast,tvalid}_o / m_axis_wr_tready_i         out/in  DW,DW/8,1,1 / 1    write payload
//  m_rd_req_{valid,vaddr,len}_o / m_rd_req_ready_i                     out/in  1,64,28 / 1        read request to stack
//  s_axis_rd_{tdata,tkeep,tlast,tvalid}_i / s_axis_rd_tready_o         in/out  DW,DW/8,1,1 / 1    read payload
// BEHAVIOUR
//  Reset, async assert and sync release:
//  - Every valid/ready output is 0; all registered data/id/resp outputs are 0; both FSMs go to IDLE.
//  - Reset mid-burst abandons the burst; no partial B or R is issued afterwards.
//  Write FSM, states W_IDLE, W_REQ, W_DATA, W_DROP, W_RESP:
//  - awready=1 only in W_IDLE. An AW handshake at cycle N latches id, addr, len and err.
//  - err = (awburst!=INCR) | (awsize!=log2(BEAT_BYTES)).
//  - If !err, go to W_REQ: m_wr_req_valid_o=1 from N+1; vaddr=awaddr; len=(awlen+1)*BEAT_BYTES, zero-extended to 28 bits. Hold until ready, then go to W_DATA.
//  - If err, go to W_DROP: wready=1, beats are discarded and no request is issued.
//  - W_DATA is a combinational pass-through: tvalid=wvalid, wready=tready, tdata=wdata, tkeep=wstrb, tlast=(beat_cnt==awlen).
//  - beat_cnt is 8 bits and increments per accepted beat. The state is left on the beat with beat_cnt==awlen.
//  - The flag wlast_err is set if wlast!=(beat_cnt==awlen) on any accepted beat.
//  - W_RESP: bvalid=1 on the cycle after the final W beat. bresp=SLVERR if err|wlast_err, else OKAY; bid=awid. Hold until bready, then return to W_IDLE.
//  Read FSM, states R_IDLE, R_REQ, R_DATA, R_PAD, R_DRAIN:
//  - arready=1 only in R_IDLE. Latch fields and err exactly as for writes.
//  - If !err, go to R_REQ (rd_req, same rules as writes), then R_DATA.
//  - If err, go straight to R_PAD with SLVERR.
//  - R_DATA is a pass-through: rvalid=tvalid, tready=rready, rdata=tdata, rresp=OKAY, rid=arid, rlast=(beat_cnt==arlen).
//  - Early tlast (tlast && beat_cnt<arlen): that beat goes out with OKAY, then go to R_PAD.
//  - R_PAD: rvalid=1, rdata=0, rresp=SLVERR, stream not consumed, until the beat with beat_cnt==arlen (rlast) is accepted.
//  - Missing tlast on the final beat: after rlast, go to R_DRAIN. tready=1 there, beats are discarded, until tlast is consumed; then R_IDLE.
//  - Normal completion, tlast on the final beat: go to R_IDLE.
//  Common rules:
//  - The read and write FSMs are fully independent, and simultaneous AW and AR are both accepted.
//  - One outstanding burst per direction; no AXI interleaving or reordering.
//  - awlen=0 / arlen=0 is a single beat with tlast/rlast on beat 0.
//  - awlen=255 gives len=256*BEAT_BYTES=16384; the beat counter never wraps within a burst.
//  - Outputs driven from FSM state are registered; pass-through paths are combinational, with zero-cycle latency.
// STRUCTURE
//  roceTypes package gets:
//  - AXI_RESP_OKAY=2'b00, AXI_RESP_SLVERR=2'b10, AXI_BURST_INCR=2'b01
//  - typedef axi_slv_req_t {id, addr[63:0], len[7:0], err}
//  - enum types wr_state_e and rd_state_e
//  Optional single sub-module roce_stack_aximm_burst_ctr: beat counter plus last/err compare, instanced once per direction.
// TESTING
//  1. AW addr=0x1000 len=3 INCR size=6, 4 W beats with wlast on beat 3 -> one wr_req vaddr=0x1000 len=256; 4 AXIS beats, tlast on the 4th; bresp=OKAY, bid echoed.
//  2. AR addr=0x2000 len=1, stream returns 2 beats with tlast on the 2nd -> rd_req len=128; 2 R beats OKAY, rlast on the 2nd.
//  3. AR len=3, stream tlast on beat 1 -> R beats 0-1 OKAY, beats 2-3 rdata=0 SLVERR, rlast on beat 3.
//  4. AW burst=FIXED len=1 -> no wr_req; 2 W beats accepted; bresp=SLVERR.
//  5. AR len=0 while the stream sends 3 beats with tlast on the 3rd -> 1 R beat with rlast; 2 beats drained; next AR accepted afterwards.
//  6. Concurrent AW and AR, random tready/rready/bready stalls, aresetn pulsed mid-W -> no data loss under stalls; after reset all valids are 0, a fresh AW completes with OKAY, and no stale B is seen.

Source files
------------

// File: rtl/roce_stack_aximm_to_axis_pkg.sv
// Shared AXI encodings, latched burst descriptor and FSM state types for the
// AXI4-MM slave to RoCE stack stream bridge.
package roce_stack_aximm_to_axis_pkg;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  typedef struct packed {
    logic        id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic        err;
  } axi_slv_req_t;

  typedef enum logic [2:0] {W_IDLE, W_REQ, W_DATA, W_DROP, W_RESP} wr_state_e;
  typedef enum logic [2:0] {R_IDLE, R_REQ, R_DATA, R_PAD, R_DRAIN} rd_state_e;
endpackage

// File: rtl/roce_stack_aximm_to_axis_burst_ctr.sv
// Per-burst beat counter; flags the beat whose index equals the AXI len field.
module roce_stack_aximm_burst_ctr (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       inc_i,
  input  logic [7:0] len_i,
  output logic       last_o
);
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign last_o = (cnt_q == len_i);
endmodule

// File: rtl/roce_stack_aximm_to_axis.sv
// AXI4-MM slave front end for the RoCE data plane: write bursts become a write
// request plus payload stream, read bursts a read request whose stream is replayed as R.
module roce_stack_aximm_to_axis
  import roce_stack_aximm_to_axis_pkg::*;
#(
  parameter int AXI4_DATA_WIDTH = 512
) (
  input  logic                         axis_aclk_i,
  input  logic                         aresetn_i,
  input  logic                         s_axi_awid_i,
  input  logic [63:0]                  s_axi_awaddr_i,
  input  logic [7:0]                   s_axi_awlen_i,
  input  logic [2:0]                   s_axi_awsize_i,
  input  logic [1:0]                   s_axi_awburst_i,
  input  logic                         s_axi_awvalid_i,
  output logic                         s_axi_awready_o,
  input  logic [AXI4_DATA_WIDTH-1:0]   s_axi_wdata_i,
  input  logic [AXI4_DATA_WIDTH/8-1:0] s_axi_wstrb_i,
  input  logic                         s_axi_wlast_i,
  input  logic                         s_axi_wvalid_i,
  output logic                         s_axi_wready_o,
  output logic                         s_axi_bid_o,
  output logic [1:0]                   s_axi_bresp_o,
  output logic                         s_axi_bvalid_o,
  input  logic                         s_axi_bready_i,
  input  logic                         s_axi_arid_i,
  input  logic [63:0]                  s_axi_araddr_i,
  input  logic [7:0]                   s_axi_arlen_i,
  input  logic [2:0]                   s_axi_arsize_i,
  input  logic [1:0]                   s_axi_arburst_i,
  input  logic                         s_axi_arvalid_i,
  output logic                         s_axi_arready_o,
  output logic                         s_axi_rid_o,
  output logic [AXI4_DATA_WIDTH-1:0]   s_axi_rdata_o,
  output logic [1:0]                   s_axi_rresp_o,
  output logic                         s_axi_rlast_o,
  output logic                         s_axi_rvalid_o,
  input  logic                         s_axi_rready_i,
  output logic                         m_wr_req_valid_o,
  output logic [63:0]                  m_wr_req_vaddr_o,
  output logic [27:0]                  m_wr_req_len_o,
  input  logic                         m_wr_req_ready_i,
  output logic [AXI4_DATA_WIDTH-1:0]   m_axis_wr_tdata_o,
  output logic [AXI4_DATA_WIDTH/8-1:0] m_axis_wr_tkeep_o,
  output logic                         m_axis_wr_tlast_o,
  output logic                         m_axis_wr_tvalid_o,
  input  logic                         m_axis_wr_tready_i,
  output logic                         m_rd_req_valid_o,
  output logic [63:0]                  m_rd_req_vaddr_o,
  output logic [27:0]                  m_rd_req_len_o,
  input  logic                         m_rd_req_ready_i,
  input  logic [AXI4_DATA_WIDTH-1:0]   s_axis_rd_tdata_i,
  input  logic [AXI4_DATA_WIDTH/8-1:0] s_axis_rd_tkeep_i,
  input  logic                         s_axis_rd_tlast_i,
  input  logic                         s_axis_rd_tvalid_i,
  output logic                         s_axis_rd_tready_o
);
  localparam int         BEAT_BYTES = AXI4_DATA_WIDTH / 8;
  localparam logic [2:0] BEAT_SIZE  = 3'($clog2(BEAT_BYTES));

  function automatic logic req_err(input logic [1:0] burst, input logic [2:0] size);
    return (burst != AXI_BURST_INCR) || (size != BEAT_SIZE);
  endfunction

  function automatic logic [27:0] req_bytes(input logic [7:0] len);
    return (28'(len) + 28'd1) * 28'(BEAT_BYTES);
  endfunction

  wr_state_e    w_state_q, w_state_d;
  axi_slv_req_t wr_q, wr_d;
  logic [27:0]  wr_len_q, wr_len_d;
  logic         wlast_err_q, wlast_err_d;
  logic [1:0]   bresp_q, bresp_d;
  logic         awready_q, wreq_vld_q, bvalid_q;
  logic         aw_hs, w_beat, w_last;

  rd_state_e    r_state_q, r_state_d;
  axi_slv_req_t rd_q, rd_d;
  logic [27:0]  rd_len_q, rd_len_d;
  logic         arready_q, rreq_vld_q;
  logic         ar_hs, r_beat, r_last;

  logic         unused_ok;
  assign unused_ok = ^{s_axis_rd_tkeep_i, rd_q.err};

  assign aw_hs = s_axi_awvalid_i && awready_q;
  assign ar_hs = s_axi_arvalid_i && arready_q;

  roce_stack_aximm_burst_ctr u_wr_ctr (
    .clk_i (axis_aclk_i), .rst_ni (aresetn_i), .clr_i (aw_hs), .inc_i (w_beat),
    .len_i (wr_q.len),    .last_o (w_last)
  );

  roce_stack_aximm_burst_ctr u_rd_ctr (
    .clk_i (axis_aclk_i), .rst_ni (aresetn_i), .clr_i (ar_hs), .inc_i (r_beat),
    .len_i (rd_q.len),    .last_o (r_last)
  );

  always_comb begin
    w_state_d          = w_state_q;
    wr_d               = wr_q;
    wr_len_d           = wr_len_q;
    wlast_err_d        = wlast_err_q;
    bresp_d            = bresp_q;
    w_beat             = 1'b0;
    s_axi_wready_o     = 1'b0;
    m_axis_wr_tvalid_o = 1'b0;
    unique case (w_state_q)
      W_IDLE: if (aw_hs) begin
        wr_d.id     = s_axi_awid_i;
        wr_d.addr   = s_axi_awaddr_i;
        wr_d.len    = s_axi_awlen_i;
        wr_d.err    = req_err(s_axi_awburst_i, s_axi_awsize_i);
        wr_len_d    = req_bytes(s_axi_awlen_i);
        wlast_err_d = 1'b0;
        w_state_d   = wr_d.err ? W_DROP : W_REQ;
      end
      W_REQ: if (wreq_vld_q && m_wr_req_ready_i) w_state_d = W_DATA;
      W_DATA: begin
        m_axis_wr_tvalid_o = s_axi_wvalid_i;
        s_axi_wready_o     = m_axis_wr_tready_i;
        w_beat             = s_axi_wvalid_i && m_axis_wr_tready_i;
      end
      W_DROP: begin
        s_axi_wready_o = 1'b1;
        w_beat         = s_axi_wvalid_i;
      end
      W_RESP: if (bvalid_q && s_axi_bready_i) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
    if (w_beat) begin
      if (s_axi_wlast_i != w_last) wlast_err_d = 1'b1;
      if (w_last) begin
        w_state_d = W_RESP;
        bresp_d   = (wr_q.err || wlast_err_d) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      end
    end
  end

  // Handshake outputs are registered from the next state so they drop to 0 in reset.
  always_ff @(posedge axis_aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      w_state_q   <= W_IDLE;
      wr_q        <= '0;
      wr_len_q    <= '0;
      wlast_err_q <= 1'b0;
      bresp_q     <= AXI_RESP_OKAY;
      awready_q   <= 1'b0;
      wreq_vld_q  <= 1'b0;
      bvalid_q    <= 1'b0;
    end else begin
      w_state_q   <= w_state_d;
      wr_q        <= wr_d;
      wr_len_q    <= wr_len_d;
      wlast_err_q <= wlast_err_d;
      bresp_q     <= bresp_d;
      awready_q   <= (w_state_d == W_IDLE);
      wreq_vld_q  <= (w_state_d == W_REQ);
      bvalid_q    <= (w_state_d == W_RESP);
    end
  end

  assign s_axi_awready_o   = awready_q;
  assign s_axi_bvalid_o    = bvalid_q;
  assign s_axi_bid_o       = wr_q.id;
  assign s_axi_bresp_o     = bresp_q;
  assign m_wr_req_valid_o  = wreq_vld_q;
  assign m_wr_req_vaddr_o  = wr_q.addr;
  assign m_wr_req_len_o    = wr_len_q;
  assign m_axis_wr_tdata_o = s_axi_wdata_i;
  assign m_axis_wr_tkeep_o = s_axi_wstrb_i;
  assign m_axis_wr_tlast_o = w_last;

  always_comb begin
    r_state_d          = r_state_q;
    rd_d               = rd_q;
    rd_len_d           = rd_len_q;
    r_beat             = 1'b0;
    s_axi_rvalid_o     = 1'b0;
    s_axi_rdata_o      = '0;
    s_axi_rresp_o      = AXI_RESP_OKAY;
    s_axi_rlast_o      = 1'b0;
    s_axis_rd_tready_o = 1'b0;
    unique case (r_state_q)
      R_IDLE: if (ar_hs) begin
        rd_d.id   = s_axi_arid_i;
        rd_d.addr = s_axi_araddr_i;
        rd_d.len  = s_axi_arlen_i;
        rd_d.err  = req_err(s_axi_arburst_i, s_axi_arsize_i);
        rd_len_d  = req_bytes(s_axi_arlen_i);
        r_state_d = rd_d.err ? R_PAD : R_REQ;
      end
      R_REQ: if (rreq_vld_q && m_rd_req_ready_i) r_state_d = R_DATA;
      R_DATA: begin
        s_axi_rvalid_o     = s_axis_rd_tvalid_i;
        s_axis_rd_tready_o = s_axi_rready_i;
        s_axi_rdata_o      = s_axis_rd_tdata_i;
        s_axi_rlast_o      = r_last;
        r_beat             = s_axis_rd_tvalid_i && s_axi_rready_i;
        if (r_beat) begin
          if (r_last)                 r_state_d = s_axis_rd_tlast_i ? R_IDLE : R_DRAIN;
          else if (s_axis_rd_tlast_i) r_state_d = R_PAD;
        end
      end
      // Stream ended early (or the burst was rejected): fill out the burst with error beats.
      R_PAD: begin
        s_axi_rvalid_o = 1'b1;
        s_axi_rresp_o  = AXI_RESP_SLVERR;
        s_axi_rlast_o  = r_last;
        r_beat         = s_axi_rready_i;
        if (r_beat && r_last) r_state_d = R_IDLE;
      end
      R_DRAIN: begin
        s_axis_rd_tready_o = 1'b1;
        if (s_axis_rd_tvalid_i && s_axis_rd_tlast_i) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      r_state_q  <= R_IDLE;
      rd_q       <= '0;
      rd_len_q   <= '0;
      arready_q  <= 1'b0;
      rreq_vld_q <= 1'b0;
    end else begin
      r_state_q  <= r_state_d;
      rd_q       <= rd_d;
      rd_len_q   <= rd_len_d;
      arready_q  <= (r_state_d == R_IDLE);
      rreq_vld_q <= (r_state_d == R_REQ);
    end
  end

  assign s_axi_arready_o  = arready_q;
  assign s_axi_rid_o      = rd_q.id;
  assign m_rd_req_valid_o = rreq_vld_q;
  assign m_rd_req_vaddr_o = rd_q.addr;
  assign m_rd_req_len_o   = rd_len_q;
endmodule

// File: tb/tb_roce_stack_aximm_to_axis.sv
// Scoreboard bench for roce_stack_aximm_to_axis: drivers push expected requests,
// payload beats and responses; negedge monitors pop and compare on each handshake.
module tb_roce_stack_aximm_to_axis;
  localparam int DW  = 512;
  localparam int KW  = DW / 8;
  localparam int TMO = 500;

  logic          clk, rstn;
  logic          awid, awvalid, awready, wlast, wvalid, wready, bid, bvalid, bready;
  logic [63:0]   awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [2:0]    awsize, arsize;
  logic [1:0]    awburst, arburst, bresp, rresp;
  logic [DW-1:0] wdata, rdata, wax_data, srd_data;
  logic [KW-1:0] wstrb, wax_keep, srd_keep;
  logic          arid, arvalid, arready, rid, rlast, rvalid, rready;
  logic          wreq_valid, wreq_ready, rreq_valid, rreq_ready;
  logic [63:0]   wreq_vaddr, rreq_vaddr;
  logic [27:0]   wreq_len, rreq_len;
  logic          wax_last, wax_valid, wax_ready, srd_last, srd_valid, srd_ready;

  roce_stack_aximm_to_axis #(.AXI4_DATA_WIDTH(DW)) dut (
    .axis_aclk_i(clk), .aresetn_i(rstn),
    .s_axi_awid_i(awid), .s_axi_awaddr_i(awaddr), .s_axi_awlen_i(awlen), .s_axi_awsize_i(awsize),
    .s_axi_awburst_i(awburst), .s_axi_awvalid_i(awvalid), .s_axi_awready_o(awready),
    .s_axi_wdata_i(wdata), .s_axi_wstrb_i(wstrb), .s_axi_wlast_i(wlast), .s_axi_wvalid_i(wvalid),
    .s_axi_wready_o(wready), .s_axi_bid_o(bid), .s_axi_bresp_o(bresp), .s_axi_bvalid_o(bvalid),
    .s_axi_bready_i(bready),
    .s_axi_arid_i(arid), .s_axi_araddr_i(araddr), .s_axi_arlen_i(arlen), .s_axi_arsize_i(arsize),
    .s_axi_arburst_i(arburst), .s_axi_arvalid_i(arvalid), .s_axi_arready_o(arready),
    .s_axi_rid_o(rid), .s_axi_rdata_o(rdata), .s_axi_rresp_o(rresp), .s_axi_rlast_o(rlast),
    .s_axi_rvalid_o(rvalid), .s_axi_rready_i(rready),
    .m_wr_req_valid_o(wreq_valid), .m_wr_req_vaddr_o(wreq_vaddr), .m_wr_req_len_o(wreq_len),
    .m_wr_req_ready_i(wreq_ready),
    .m_axis_wr_tdata_o(wax_data), .m_axis_wr_tkeep_o(wax_keep), .m_axis_wr_tlast_o(wax_last),
    .m_axis_wr_tvalid_o(wax_valid), .m_axis_wr_tready_i(wax_ready),
    .m_rd_req_valid_o(rreq_valid), .m_rd_req_vaddr_o(rreq_vaddr), .m_rd_req_len_o(rreq_len),
    .m_rd_req_ready_i(rreq_ready),
    .s_axis_rd_tdata_i(srd_data), .s_axis_rd_tkeep_i(srd_keep), .s_axis_rd_tlast_i(srd_last),
    .s_axis_rd_tvalid_i(srd_valid), .s_axis_rd_tready_o(srd_ready)
  );

  typedef struct {logic [63:0] addr; logic [27:0] len;} req_t;
  typedef struct {logic [DW-1:0] data; logic [KW-1:0] keep; logic last;} wbeat_t;
  typedef struct {logic id; logic [1:0] resp;} b_t;
  typedef struct {logic id; logic [DW-1:0] data; logic [1:0] resp; logic last;} r_t;

  req_t   q_wreq[$], q_rreq[$];
  wbeat_t q_wax[$];
  b_t     q_b[$];
  r_t     q_r[$];
  req_t   m_wreq, m_rreq;
  wbeat_t m_wax;
  b_t     m_b;
  r_t     m_r;
  int     n_checks = 0, n_errors = 0, b_seen = 0;
  bit     stall_en = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic rdy_sel(input int which);
    case (which)
      0:       return awready;
      1:       return wready;
      2:       return arready;
      default: return srd_ready;
    endcase
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #800000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Downstream readies: always 1 unless stalls are enabled.
  initial begin
    wreq_ready = 1'b0; rreq_ready = 1'b0; wax_ready = 1'b0; rready = 1'b0; bready = 1'b0;
    forever begin
      @(posedge clk); #1;
      wreq_ready = !stall_en || ($urandom_range(0, 2) != 0);
      rreq_ready = !stall_en || ($urandom_range(0, 2) != 0);
      wax_ready  = !stall_en || ($urandom_range(0, 2) != 0);
      rready     = !stall_en || ($urandom_range(0, 2) != 0);
      bready     = !stall_en || ($urandom_range(0, 2) != 0);
    end
  end

  always @(negedge clk) if (rstn && wreq_valid && wreq_ready) begin
    check_eq("wreq_expected", q_wreq.size() != 0, 1);
    if (q_wreq.size() != 0) begin
      m_wreq = q_wreq.pop_front();
      check_eq("wreq_vaddr", wreq_vaddr, m_wreq.addr);
      check_eq("wreq_len", wreq_len, m_wreq.len);
    end
  end

  always @(negedge clk) if (rstn && rreq_valid && rreq_ready) begin
    check_eq("rreq_expected", q_rreq.size() != 0, 1);
    if (q_rreq.size() != 0) begin
      m_rreq = q_rreq.pop_front();
      check_eq("rreq_vaddr", rreq_vaddr, m_rreq.addr);
      check_eq("rreq_len", rreq_len, m_rreq.len);
    end
  end

  always @(negedge clk) if (rstn && wax_valid && wax_ready) begin
    check_eq("wax_expected", q_wax.size() != 0, 1);
    if (q_wax.size() != 0) begin
      m_wax = q_wax.pop_front();
      check_eq("wax_tdata", wax_data, m_wax.data);
      check_eq("wax_tkeep", wax_keep, m_wax.keep);
      check_eq("wax_tlast", wax_last, m_wax.last);
    end
  end

  always @(negedge clk) if (rstn && bvalid && bready) begin
    b_seen++;
    check_eq("b_expected", q_b.size() != 0, 1);
    if (q_b.size() != 0) begin
      m_b = q_b.pop_front();
      check_eq("bid", bid, m_b.id);
      check_eq("bresp", bresp, m_b.resp);
    end
  end

  always @(negedge clk) if (rstn && rvalid && rready) begin
    check_eq("r_expected", q_r.size() != 0, 1);
    if (q_r.size() != 0) begin
      m_r = q_r.pop_front();
      check_eq("rid", rid, m_r.id);
      check_eq("rdata", rdata, m_r.data);
      check_eq("rresp", rresp, m_r.resp);
      check_eq("rlast", rlast, m_r.last);
    end
  end

  task automatic wait_rdy(input int which, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!rdy_sel(which) && n < TMO) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_handshake"}, rdy_sel(which), 1);
  endtask

  task automatic send_aw(input logic id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [2:0] size);
    if (burst == 2'b01 && size == 3'd6) q_wreq.push_back('{addr, {20'd0, len} * 28'd64 + 28'd64});
    @(posedge clk); #1;
    awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = size; awvalid = 1'b1;
    wait_rdy(0, "aw");
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic send_ar(input logic id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [2:0] size);
    if (burst == 2'b01 && size == 3'd6) q_rreq.push_back('{addr, {20'd0, len} * 28'd64 + 28'd64});
    @(posedge clk); #1;
    arid = id; araddr = addr; arlen = len; arburst = burst; arsize = size; arvalid = 1'b1;
    wait_rdy(2, "ar");
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  // Sends nsend W beats; the B expectation is queued only when the burst is complete.
  task automatic send_w(input logic id, input logic [7:0] len, input logic err,
                        input int bad_last, input int gap_max, input int nsend);
    logic bad, wl;
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    int gap;
    bad = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < nsend; i++) begin
      d  = rand_data();
      k  = {$urandom, $urandom};
      wl = (i == int'(len));
      if (i == bad_last) wl = !wl;
      if (wl != (i == int'(len))) bad = 1'b1;
      if (!err) q_wax.push_back('{d, k, (i == int'(len))});
      wdata = d; wstrb = k; wlast = wl; wvalid = 1'b1;
      wait_rdy(1, "w");
      @(posedge clk); #1;
      if (i == int'(len)) q_b.push_back('{id, (err || bad) ? 2'b10 : 2'b00});
      gap = $urandom_range(0, gap_max);
      if (gap > 0) wvalid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    wvalid = 1'b0;
  endtask

  task automatic send_stream(input logic [DW-1:0] sd[$], input int gap_max);
    int gap;
    @(posedge clk); #1;
    for (int i = 0; i < sd.size(); i++) begin
      srd_data = sd[i]; srd_keep = '1; srd_last = (i == sd.size() - 1); srd_valid = 1'b1;
      wait_rdy(3, "stream");
      @(posedge clk); #1;
      gap = $urandom_range(0, gap_max);
      if (gap > 0) srd_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    srd_valid = 1'b0;
  endtask

  task automatic do_write(input logic id, input logic [63:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size,
                          input int bad_last, input int gap_max);
    logic err;
    err = (burst != 2'b01) || (size != 3'd6);
    fork
      send_aw(id, addr, len, burst, size);
      send_w(id, len, err, bad_last, gap_max, int'(len) + 1);
    join
  endtask

  // nbeats is the stream length; tlast is on its final beat.
  task automatic do_read(input logic id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [2:0] size,
                         input int nbeats, input int gap_max);
    logic [DW-1:0] sd[$];
    logic err;
    err = (burst != 2'b01) || (size != 3'd6);
    for (int i = 0; i < nbeats; i++) sd.push_back(rand_data());
    for (int i = 0; i <= int'(len); i++) begin
      if (!err && i < nbeats) q_r.push_back('{id, sd[i], 2'b00, (i == int'(len))});
      else                    q_r.push_back('{id, {DW{1'b0}}, 2'b10, (i == int'(len))});
    end
    fork
      send_ar(id, addr, len, burst, size);
      begin
        if (!err) send_stream(sd, gap_max);
      end
    join
  endtask

  task automatic wait_idle();
    for (int n = 0; n < TMO; n++) begin
      if (q_wreq.size() == 0 && q_rreq.size() == 0 && q_wax.size() == 0 &&
          q_b.size() == 0 && q_r.size() == 0) break;
      @(posedge clk); #1;
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_awready"}, awready, 0);
    check_eq({tag, "_wready"}, wready, 0);
    check_eq({tag, "_bvalid"}, bvalid, 0);
    check_eq({tag, "_arready"}, arready, 0);
    check_eq({tag, "_rvalid"}, rvalid, 0);
    check_eq({tag, "_wreq_valid"}, wreq_valid, 0);
    check_eq({tag, "_rreq_valid"}, rreq_valid, 0);
    check_eq({tag, "_wax_tvalid"}, wax_valid, 0);
    check_eq({tag, "_srd_tready"}, srd_ready, 0);
  endtask

  task automatic check_queues_empty(input string tag);
    check_eq({tag, "_wreq_left"}, q_wreq.size(), 0);
    check_eq({tag, "_rreq_left"}, q_rreq.size(), 0);
    check_eq({tag, "_wax_left"}, q_wax.size(), 0);
    check_eq({tag, "_b_left"}, q_b.size(), 0);
    check_eq({tag, "_r_left"}, q_r.size(), 0);
  endtask

  int b_mark;

  initial begin
    rstn = 1'b0;
    awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awvalid = 0;
    wdata = '0; wstrb = '0; wlast = 0; wvalid = 0;
    arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arvalid = 0;
    srd_data = '0; srd_keep = '0; srd_last = 0; srd_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("rst");
    check_eq("rst_bid", bid, 0);
    check_eq("rst_bresp", bresp, 0);
    check_eq("rst_rid", rid, 0);
    check_eq("rst_wreq_vaddr", wreq_vaddr, 0);
    check_eq("rst_wreq_len", wreq_len, 0);
    check_eq("rst_rreq_vaddr", rreq_vaddr, 0);
    check_eq("rst_rreq_len", rreq_len, 0);
    rstn = 1'b1;

    do_write(1'b1, 64'h1000, 8'd3, 2'b01, 3'd6, -1, 0);
    do_read(1'b0, 64'h2000, 8'd1, 2'b01, 3'd6, 2, 0);
    do_read(1'b1, 64'h3000, 8'd3, 2'b01, 3'd6, 2, 1);
    wait_idle();
    do_write(1'b0, 64'h4000, 8'd1, 2'b00, 3'd6, -1, 0);
    do_write(1'b1, 64'h4100, 8'd1, 2'b01, 3'd6, 0, 0);
    do_read(1'b0, 64'h4200, 8'd1, 2'b01, 3'd5, 0, 0);
    do_read(1'b0, 64'h5000, 8'd0, 2'b01, 3'd6, 3, 0);
    do_read(1'b1, 64'h5040, 8'd0, 2'b01, 3'd6, 1, 0);
    do_write(1'b1, 64'h8000, 8'd255, 2'b01, 3'd6, -1, 0);
    wait_idle();
    check_queues_empty("directed");

    stall_en = 1;
    fork
      do_write(1'b1, 64'h6000, 8'd7, 2'b01, 3'd6, -1, 2);
      do_read(1'b0, 64'h7000, 8'd5, 2'b01, 3'd6, 6, 2);
    join
    fork
      do_write(1'b0, 64'h6400, 8'd2, 2'b01, 3'd6, -1, 1);
      do_read(1'b1, 64'h7400, 8'd4, 2'b01, 3'd6, 2, 1);
    join
    wait_idle();
    stall_en = 0;
    check_queues_empty("stall");
    repeat (2) begin @(posedge clk); #1; end

    fork
      send_aw(1'b0, 64'h9000, 8'd7, 2'b01, 3'd6);
      send_w(1'b0, 8'd7, 1'b0, -1, 0, 3);
    join
    rstn = 1'b0;
    #1;
    check_quiet("midrst");
    check_queues_empty("midrst");
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    #1;
    check_quiet("postrst");
    b_mark = b_seen;
    do_write(1'b1, 64'hA000, 8'd2, 2'b01, 3'd6, -1, 0);
    wait_idle();
    repeat (20) begin @(posedge clk); #1; end
    check_eq("b_count_after_rst", b_seen - b_mark, 1);
    check_queues_empty("final");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
